// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one word-addressed 32-bit memory bus between
// NUM_REQ masters, with a watchdog that aborts accesses the memory never
// completes.
//
// Handshake: a master raises req_read and/or req_write with its address and
// data and holds them until it sees its req_complete bit (one cycle, with
// req_read_data/req_error valid in that same cycle); it must drop the request
// on the edge that ends that cycle. On the memory side read/write stay high
// and stable until access_complete is seen high on a rising edge; read_data is
// taken in that same cycle.
module mem_bus_arbiter #(
   parameter int          NUM_REQ        = 2,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_read,
   input  logic [NUM_REQ-1:0]    req_write,
   input  logic [NUM_REQ*30-1:0] req_address,
   input  logic [NUM_REQ*32-1:0] req_write_data,
   output logic [31:0]           req_read_data,
   output logic [NUM_REQ-1:0]    req_complete,
   output logic                  req_error,
   output logic                  read,
   output logic                  write,
   output logic [29:0]           address,
   output logic [31:0]           write_data,
   input  logic [31:0]           read_data,
   input  logic                  access_complete,
   output logic [1:0]            dbg_state
);

   localparam int PTR_W = $clog2(NUM_REQ);
   // A zero-width counter is illegal, so keep one bit when the watchdog is off.
   localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   gnt_q, gnt_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic               read_q, read_d;
   logic               write_q, write_d;
   logic [29:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [NUM_REQ-1:0] cmpl_q, cmpl_d;
   logic               err_q, err_d;

   logic [NUM_REQ-1:0] pend;
   logic               any_pend;
   logic [PTR_W-1:0]   win;

   // (p + k) mod NUM_REQ for 1 <= k <= NUM_REQ.
   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PTR_W'(s);
   endfunction

   // Round-robin search: first pending master after the last one served.
   always_comb begin
      pend     = req_read | req_write;
      any_pend = 1'b0;
      win      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!any_pend && pend[wrap_idx(ptr_q, k)]) begin
            any_pend = 1'b1;
            win      = wrap_idx(ptr_q, k);
         end
      end
   end

   // Next-state and output logic of the IDLE -> ACCESS -> DONE sequence.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      wd_d    = wd_q;
      read_d  = read_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      cmpl_d  = '0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (any_pend) begin
               state_d = S_ACCESS;
               gnt_d   = win;
               addr_d  = req_address[30*int'(win) +: 30];
               wdata_d = req_write_data[32*int'(win) +: 32];
               // Write takes precedence when a master raises both strobes.
               write_d = req_write[win];
               read_d  = req_read[win] & ~req_write[win];
               wd_d    = '0;
            end
         end
         S_ACCESS: begin
            if (access_complete) begin
               state_d = S_DONE;
               rdata_d = read_data;
               cmpl_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
               read_d  = 1'b0;
               write_d = 1'b0;
               ptr_d   = gnt_q;
            end else if (TIMEOUT_CYCLES != 0 && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_DONE;
               rdata_d = ERR_DATA;
               cmpl_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
               err_d   = 1'b1;
               read_d  = 1'b0;
               write_d = 1'b0;
               ptr_d   = gnt_q;
            end else if (TIMEOUT_CYCLES != 0) begin
               // Abort fires at TIMEOUT_CYCLES-1, so this never wraps.
               wd_d = wd_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; reset drops the bus strobes immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         gnt_q   <= '0;
         wd_q    <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cmpl_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         wd_q    <= wd_d;
         read_q  <= read_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cmpl_q  <= cmpl_d;
         err_q   <= err_d;
      end
   end

   assign read          = read_q;
   assign write         = write_q;
   assign address       = addr_q;
   assign write_data    = wdata_q;
   assign req_read_data = rdata_q;
   assign req_complete  = cmpl_q;
   assign req_error     = err_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected bus accesses and completions
// are queued as stimulus is issued; a monitor pops and compares them whenever
// the arbiter starts a bus access or pulses req_complete.
module tb_mem_bus_arbiter;

   localparam int          N   = 2;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   localparam int          BW  = 72;     // {read, write, address, write_data, len}
   localparam int          CW  = N + 33; // {req_complete, req_error, req_read_data}
   localparam int          RW  = 40;     // {latency (255 = never), read_data}

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_read, req_write;
   logic [N*30-1:0] req_address;
   logic [N*32-1:0] req_write_data;
   logic [31:0]     req_read_data;
   logic [N-1:0]    req_complete;
   logic            req_error;
   logic            read, write;
   logic [29:0]     address;
   logic [31:0]     write_data;
   logic [31:0]     read_data;
   logic            access_complete;
   logic [1:0]      dbg_state;

   logic [BW-1:0] exp_bus_q[$];
   logic [CW-1:0] exp_q[$];
   logic [RW-1:0] resp_q[$];
   int            start_q[$];
   int            req_left[N];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;

   mem_bus_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8), .ERR_DATA(ERR)) dut (
      .clk(clk), .reset(reset),
      .req_read(req_read), .req_write(req_write),
      .req_address(req_address), .req_write_data(req_write_data),
      .req_read_data(req_read_data), .req_complete(req_complete), .req_error(req_error),
      .read(read), .write(write), .address(address), .write_data(write_data),
      .read_data(read_data), .access_complete(access_complete),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic issue(input int m, input logic rd, input logic wr,
                        input logic [29:0] a, input logic [31:0] d, input int cnt);
      req_left[m]                 = cnt;
      req_address[30*m +: 30]     = a;
      req_write_data[32*m +: 32]  = d;
      req_read[m]                 = rd;
      req_write[m]                = wr;
   endtask

   task automatic push_bus(input logic rd, input logic wr, input logic [29:0] a,
                           input logic [31:0] d, input logic [7:0] len);
      exp_bus_q.push_back({rd, wr, a, d, len});
   endtask

   task automatic push_cmp(input logic [N-1:0] c, input logic e, input logic [31:0] dat);
      exp_q.push_back({c, e, dat});
   endtask

   task automatic push_resp(input logic [7:0] lat, input logic [31:0] dat);
      resp_q.push_back({lat, dat});
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || exp_bus_q.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0 || exp_bus_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d completions and %0d accesses outstanding, required 0",
                  name, exp_q.size(), exp_bus_q.size());
         exp_q.delete();
         exp_bus_q.delete();
      end
   endtask

   // Memory model: completes each access after the latency queued for it.
   initial begin : responder
      int            cnt;
      logic [7:0]    lat;
      logic [31:0]   rd;
      logic [RW-1:0] r;
      cnt = 0; lat = 8'd255; rd = '0;
      access_complete = 1'b0;
      read_data       = '0;
      forever begin
         @(posedge clk);
         #1;
         if (read || write) begin
            if (cnt == 0) begin
               if (resp_q.size() > 0) r = resp_q.pop_front();
               else r = {8'd255, 32'h0};
               lat = r[39:32];
               rd  = r[31:0];
            end
            cnt++;
            if (lat != 8'd255 && cnt == int'(lat) + 1) begin
               access_complete = 1'b1;
               read_data       = rd;
            end else begin
               access_complete = 1'b0;
               read_data       = '0;
            end
         end else begin
            cnt             = 0;
            access_complete = 1'b0;
            read_data       = '0;
         end
      end
   end

   // Master model: drops a request during its completion cycle once its
   // access count is used up.
   initial begin : master_agent
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (req_complete[i] && req_left[i] > 0) begin
               req_left[i]--;
               if (req_left[i] == 0) begin
                  req_read[i]  = 1'b0;
                  req_write[i] = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   initial begin : monitor
      logic          prev_act;
      int            run;
      logic [7:0]    exp_len;
      logic [BW-1:0] eb;
      logic [CW-1:0] ec;
      prev_act = 1'b0; run = 0; exp_len = '0;
      forever begin
         @(negedge clk);
         if (req_complete != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL cmp_unexpected: got complete=%b err=%b data=%h, required no completion",
                        req_complete, req_error, req_read_data);
            end else begin
               ec = exp_q.pop_front();
               if ({req_complete, req_error, req_read_data} !== ec) begin
                  errors++;
                  $display("FAIL cmp: got complete=%b err=%b data=%h, required complete=%b err=%b data=%h",
                           req_complete, req_error, req_read_data,
                           ec[CW-1:33], ec[32], ec[31:0]);
               end
            end
         end
         if ((read || write) && !prev_act) begin
            start_q.push_back(cyc);
            run = 1;
            checks++;
            if (exp_bus_q.size() == 0) begin
               errors++;
               exp_len = '0;
               $display("FAIL bus_unexpected: got rd=%b wr=%b addr=%h data=%h, required no access",
                        read, write, address, write_data);
            end else begin
               eb      = exp_bus_q.pop_front();
               exp_len = eb[7:0];
               if ({read, write, address, write_data} !== eb[BW-1:8]) begin
                  errors++;
                  $display("FAIL bus: got rd=%b wr=%b addr=%h data=%h, required rd=%b wr=%b addr=%h data=%h",
                           read, write, address, write_data,
                           eb[71], eb[70], eb[69:40], eb[39:8]);
               end
            end
         end else if (read || write) begin
            run++;
         end else if (prev_act) begin
            checks++;
            if (run != int'(exp_len)) begin
               errors++;
               $display("FAIL bus_len: got %0d cycles, required %0d", run, exp_len);
            end
         end
         prev_act = read || write;
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin : stimulus
      int base;
      int n;
      reset          = 1'b0;
      req_read       = '0;
      req_write      = '0;
      req_address    = '0;
      req_write_data = '0;
      for (int i = 0; i < N; i++) req_left[i] = 0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_bus", {read, write, address, write_data}, 64'h0);
      check("reset_resp", {req_complete, req_error, req_read_data}, 35'h0);
      check("reset_state", dbg_state, 2'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Single read by master 1, memory answers after 4 cycles.
      push_bus(1'b1, 1'b0, 30'h100, 32'h0, 8'd5);
      push_cmp(2'b10, 1'b0, 32'hCAFE_F00D);
      push_resp(8'd4, 32'hCAFE_F00D);
      issue(1, 1'b1, 1'b0, 30'h100, 32'h0, 1);
      drain("single_read");

      // Write by master 0; read_data is still captured on completion.
      push_bus(1'b0, 1'b1, 30'h3, 32'h1234_5678, 8'd3);
      push_cmp(2'b01, 1'b0, 32'h5555_AAAA);
      push_resp(8'd2, 32'h5555_AAAA);
      issue(0, 1'b0, 1'b1, 30'h3, 32'h1234_5678, 1);
      drain("write");

      // Both strobes from master 0: only write reaches the bus.
      push_bus(1'b0, 1'b1, 30'h2A, 32'hA5A5_0F0F, 8'd1);
      push_cmp(2'b01, 1'b0, 32'h0BAD_0001);
      push_resp(8'd0, 32'h0BAD_0001);
      issue(0, 1'b1, 1'b1, 30'h2A, 32'hA5A5_0F0F, 1);
      drain("both_strobes");

      // Fresh reset, then two continuously pending masters alternate.
      reset = 1'b0;
      #1;
      check("reset2_resp", {req_complete, req_error, req_read_data}, 35'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      base = start_q.size();
      push_bus(1'b1, 1'b0, 30'h10, 32'h0, 8'd1);          push_cmp(2'b01, 1'b0, 32'h1111_0001);
      push_bus(1'b0, 1'b1, 30'h20, 32'h0000_2020, 8'd1);  push_cmp(2'b10, 1'b0, 32'h2222_0002);
      push_bus(1'b1, 1'b0, 30'h10, 32'h0, 8'd1);          push_cmp(2'b01, 1'b0, 32'h3333_0003);
      push_bus(1'b0, 1'b1, 30'h20, 32'h0000_2020, 8'd1);  push_cmp(2'b10, 1'b0, 32'h4444_0004);
      push_resp(8'd0, 32'h1111_0001);
      push_resp(8'd0, 32'h2222_0002);
      push_resp(8'd0, 32'h3333_0003);
      push_resp(8'd0, 32'h4444_0004);
      issue(0, 1'b1, 1'b0, 30'h10, 32'h0, 2);
      issue(1, 1'b0, 1'b1, 30'h20, 32'h0000_2020, 2);
      drain("round_robin");
      checks++;
      if (start_q.size() < base + 4) begin
         errors++;
         $display("FAIL rr_grants: got %0d grants, required 4", start_q.size() - base);
      end else begin
         for (int k = 1; k < 4; k++)
            check($sformatf("rr_spacing%0d", k), start_q[base+k] - start_q[base+k-1], 3);
      end

      // Watchdog: master 0 is never answered, then master 1 is served.
      push_bus(1'b1, 1'b0, 30'h40, 32'h0, 8'd8);
      push_cmp(2'b01, 1'b1, ERR);
      push_resp(8'd255, 32'h0);
      push_bus(1'b0, 1'b1, 30'h50, 32'h5050_5050, 8'd2);
      push_cmp(2'b10, 1'b0, 32'h7777_0000);
      push_resp(8'd1, 32'h7777_0000);
      issue(0, 1'b1, 1'b0, 30'h40, 32'h0, 1);
      issue(1, 1'b0, 1'b1, 30'h50, 32'h5050_5050, 1);
      drain("timeout");

      // Serve master 0 so that master 1 is next in line.
      push_bus(1'b1, 1'b0, 30'h60, 32'h0, 8'd2);
      push_cmp(2'b01, 1'b0, 32'h6060_6060);
      push_resp(8'd1, 32'h6060_6060);
      issue(0, 1'b1, 1'b0, 30'h60, 32'h0, 1);
      drain("prep");

      // Reset two cycles into master 1's access: no completion, and
      // master 0 wins first after release.
      push_bus(1'b1, 1'b0, 30'h70, 32'h0, 8'd2);
      push_resp(8'd255, 32'h0);
      push_bus(1'b0, 1'b1, 30'h80, 32'h8080_8080, 8'd1);
      push_cmp(2'b01, 1'b0, 32'h8888_0008);
      push_resp(8'd0, 32'h8888_0008);
      push_bus(1'b1, 1'b0, 30'h70, 32'h0, 8'd1);
      push_cmp(2'b10, 1'b0, 32'h9999_0009);
      push_resp(8'd0, 32'h9999_0009);
      issue(0, 1'b0, 1'b1, 30'h80, 32'h8080_8080, 1);
      issue(1, 1'b1, 1'b0, 30'h70, 32'h0, 1);
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!(read || write) && n < 20);
      checks++;
      if (!(read || write)) begin
         errors++;
         $display("FAIL midreset_start: got no bus access, required one within 20 cycles");
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("midreset_drop", {read, write, req_complete, dbg_state}, 6'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      drain("midreset");
      check("resp_left", resp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin : watchdog_tb
      #200000;
      $display("FAIL tb_timeout: got no end of test, required completion within 200000 time units");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Round-robin arbiter that shares one 32-bit word-addressed memory bus (read/write/address/write_data/read_data/access_complete) between NUM_REQ bus masters. Typical masters are SPI memory bridges and a local CPU port.
Each master issues one access at a time on its own request port. The arbiter grants one master, drives the shared bus and waits for access_complete. It then returns the read data and a one-cycle completion pulse to that master.
A watchdog aborts accesses the memory side never completes.

Parameters:
NUM_REQ, 2, number of requesting masters (2..8)
TIMEOUT_CYCLES, 255, maximum cycles in ACCESS before abort; 0 disables the watchdog
ERR_DATA, 32'h0000_0000, value returned on req_read_data for an aborted access

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req_read  input  NUM_REQ  per-master read request, held until req_complete
req_write  input  NUM_REQ  per-master write request, held until req_complete
req_address  input  NUM_REQ*30  per-master word address [31:2]; master i uses slice [30*i +: 30]
req_write_data  input  NUM_REQ*32  per-master write data; master i uses slice [32*i +: 32]
req_read_data  output  32  read data for the completing master, valid while req_complete is high
req_complete  output  NUM_REQ  one-hot, one-cycle completion pulse
req_error  output  1  high with req_complete when the access was aborted by the watchdog
read  output  1  shared bus read strobe
write  output  1  shared bus write strobe
address  output  30  shared bus word address [31:2]
write_data  output  32  shared bus write data
read_data  input  32  shared bus read data, valid with access_complete
access_complete  input  1  shared bus completion, sampled only in ACCESS

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; read, write, req_complete and req_error = 0.
  - address, write_data and req_read_data = 0.
  - Priority pointer = NUM_REQ-1, so master 0 has highest priority first.
  - Watchdog counter = 0.
  - Reset mid-access drops the bus strobes immediately; no completion pulse is issued.
- State machine: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Pending(i) = req_read[i] | req_write[i].
  - If any master is pending, grant the first pending master found searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - On the clock edge: latch the winner's address and write_data onto the bus registers, and set write=req_write[g] and read=req_read[g] & ~req_write[g] (write wins if both are set).
  - Go to ACCESS and clear the watchdog.
  - No pending master: stay in IDLE with outputs idle.
- ACCESS:
  - Bus outputs are held stable; requester inputs are ignored, including the granted master changing its own inputs.
  - If access_complete=1:
    - Register req_read_data=read_data (for writes the value is don't-care, but it is still registered).
    - Set req_complete[g]=1 and req_error=0; drop read/write.
    - Set pointer=g and go to DONE.
  - Else, if TIMEOUT_CYCLES!=0 and the watchdog equals TIMEOUT_CYCLES-1:
    - Same actions as completion, except req_read_data=ERR_DATA and req_error=1.
  - Else increment the watchdog (width clog2(TIMEOUT_CYCLES+1); it never wraps).
- DONE:
  - Lasts exactly one cycle, with req_complete/req_error high.
  - Requests are not sampled. The completing master must deassert its request on the edge ending DONE.
  - Next state is IDLE; req_complete and req_error clear.
- Latency: request high in IDLE cycle 0 -> read/write high in cycle 1. access_complete high in cycle n -> req_complete in cycle n+1 -> next grant decision in cycle n+2.
  - Minimum access is 3 cycles (IDLE, ACCESS, DONE); a back-to-back master is regranted no sooner than every 3rd cycle.
- Fairness: a master that stays pending is granted within NUM_REQ accesses.
- access_complete outside ACCESS is ignored.
- read and write are never both high; at most one bit of req_complete is high.

Test Plan:
- Single read: NUM_REQ=2, master 1 reads addr 30'h100, memory returns 32'hCAFE_F00D after 4 cycles -> read=1 with address=30'h100 for 5 cycles; req_complete=2'b10 for 1 cycle with req_read_data=32'hCAFE_F00D and req_error=0.
- Write: master 0 writes 32'h1234_5678 to 30'h3 -> write=1, address=30'h3, write_data=32'h1234_5678 until access_complete; then req_complete=2'b01 with req_error=0.
- Round-robin: both masters continuously pending from reset, each access completing in 1 cycle -> grant order 0,1,0,1; grants are 3 cycles apart.
- Both strobes set: master 0 asserts req_read and req_write together -> only write=1 is driven on the bus.
- Timeout: TIMEOUT_CYCLES=8, access_complete never asserted -> read high for exactly 8 cycles; then req_complete pulse with req_error=1 and req_read_data=ERR_DATA; the next pending master is then granted.
- Reset mid-access: assert reset 2 cycles into ACCESS -> read/write drop asynchronously; no req_complete; after release, master 0 is granted first if both masters are pending.
